// File: rtl/pcf8563_ctrl.sv
// PCF8563 RTC transaction sequencer: init writes, periodic time polling and
// user time-set writes, issued one byte at a time to the iic engine.
module pcf8563_ctrl #(
    parameter logic [23:0] POLL_DIV  = 24'd5_000_000,
    parameter logic [19:0] TIMEOUT   = 20'd500_000,
    parameter logic [7:0]  INIT_SEC  = 8'h00,
    parameter logic [7:0]  INIT_MIN  = 8'h00,
    parameter logic [7:0]  INIT_HOUR = 8'h12
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       iSetReq,
    input  logic [7:0] iSetSec,
    input  logic [7:0] iSetMin,
    input  logic [7:0] iSetHour,
    output logic [1:0] oCall,
    output logic [7:0] oAddr,
    output logic [7:0] oWrData,
    input  logic       iDone,
    input  logic [7:0] iRdData,
    output logic [7:0] oSec,
    output logic [7:0] oMin,
    output logic [7:0] oHour,
    output logic       oVL,
    output logic       oValid,
    output logic       oBusy,
    output logic       oInitDone,
    output logic       oErr
);

    localparam int unsigned IDX_W = 3;
    localparam logic [1:0] CALL_IDLE = 2'b00;
    localparam logic [1:0] CALL_WR   = 2'b10;
    localparam logic [1:0] CALL_RD   = 2'b01;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_SETW, S_POLL, S_ISSUE, S_WAIT, S_GAP
    } state_e;

    typedef enum logic [1:0] {
        KIND_INIT, KIND_SET, KIND_POLL
    } kind_e;

    state_e           state_q, state_d;
    kind_e            kind_q, kind_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             set_pend_q, set_pend_d;
    logic             poll_pend_q, poll_pend_d;
    logic [7:0]       pend_sec_q, pend_sec_d, pend_min_q, pend_min_d, pend_hour_q, pend_hour_d;
    logic [7:0]       wrk_sec_q, wrk_sec_d, wrk_min_q, wrk_min_d, wrk_hour_q, wrk_hour_d;
    logic [7:0]       sh_sec_q, sh_sec_d, sh_min_q, sh_min_d;
    logic [23:0]      pcnt_q, pcnt_d;
    logic [19:0]      tcnt_q, tcnt_d;
    logic [1:0]       call_q, call_d;
    logic [7:0]       addr_q, addr_d, wdata_q, wdata_d;
    logic [7:0]       sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic             vl_q, vl_d, valid_q, valid_d, busy_q, busy_d;
    logic             init_done_q, init_done_d, err_q, err_d;

    logic [IDX_W-1:0] last_idx_c;
    logic [7:0]       byte_addr_c;
    logic [7:0]       byte_data_c;
    logic             wrap_c;

    // Address/data of the current byte for the active sequence kind
    always_comb begin
        last_idx_c  = (kind_q == KIND_INIT) ? IDX_W'(4) : IDX_W'(2);
        byte_addr_c = (kind_q == KIND_INIT) ? 8'(idx_q) : 8'(idx_q) + 8'd2;
        byte_data_c = 8'h00;
        case (kind_q)
            KIND_INIT: begin
                case (idx_q)
                    IDX_W'(2): byte_data_c = INIT_SEC & 8'h7F;
                    IDX_W'(3): byte_data_c = INIT_MIN;
                    IDX_W'(4): byte_data_c = INIT_HOUR;
                    default:   byte_data_c = 8'h00;
                endcase
            end
            KIND_SET: begin
                case (idx_q)
                    IDX_W'(0): byte_data_c = wrk_sec_q & 8'h7F;
                    IDX_W'(1): byte_data_c = wrk_min_q;
                    default:   byte_data_c = wrk_hour_q;
                endcase
            end
            default: byte_data_c = 8'h00;
        endcase
        wrap_c = (pcnt_q == POLL_DIV - 24'd1);
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        idx_d       = idx_q;
        set_pend_d  = set_pend_q;
        poll_pend_d = poll_pend_q | wrap_c;
        pend_sec_d  = pend_sec_q;
        pend_min_d  = pend_min_q;
        pend_hour_d = pend_hour_q;
        wrk_sec_d   = wrk_sec_q;
        wrk_min_d   = wrk_min_q;
        wrk_hour_d  = wrk_hour_q;
        sh_sec_d    = sh_sec_q;
        sh_min_d    = sh_min_q;
        pcnt_d      = wrap_c ? 24'd0 : pcnt_q + 24'd1;
        tcnt_d      = tcnt_q;
        call_d      = call_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        vl_d        = vl_q;
        valid_d     = 1'b0;
        init_done_d = init_done_q;
        err_d       = err_q;
        busy_d      = !((state_q == S_IDLE) && !set_pend_q && !poll_pend_q);

        // A newer request overwrites values that have not been started yet
        if (iSetReq) begin
            set_pend_d  = 1'b1;
            pend_sec_d  = iSetSec;
            pend_min_d  = iSetMin;
            pend_hour_d = iSetHour;
        end

        case (state_q)
            S_INIT: begin
                kind_d  = KIND_INIT;
                idx_d   = '0;
                state_d = S_ISSUE;
            end
            S_IDLE: begin
                if (init_done_q) begin
                    if (set_pend_q) begin
                        state_d    = S_SETW;
                        set_pend_d = iSetReq;
                        wrk_sec_d  = pend_sec_q;
                        wrk_min_d  = pend_min_q;
                        wrk_hour_d = pend_hour_q;
                    end else if (poll_pend_q) begin
                        state_d     = S_POLL;
                        poll_pend_d = wrap_c;
                    end
                end
            end
            S_SETW: begin
                kind_d  = KIND_SET;
                idx_d   = '0;
                state_d = S_ISSUE;
            end
            S_POLL: begin
                kind_d  = KIND_POLL;
                idx_d   = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                call_d  = (kind_q == KIND_POLL) ? CALL_RD : CALL_WR;
                addr_d  = byte_addr_c;
                wdata_d = byte_data_c;
                tcnt_d  = 20'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (iDone) begin
                    call_d  = CALL_IDLE;
                    state_d = S_GAP;
                    if (kind_q == KIND_POLL) begin
                        case (idx_q)
                            IDX_W'(0): sh_sec_d = iRdData;
                            IDX_W'(1): sh_min_d = iRdData;
                            default: begin
                                sec_d   = sh_sec_q & 8'h7F;
                                min_d   = sh_min_q & 8'h7F;
                                hour_d  = iRdData & 8'h3F;
                                vl_d    = sh_sec_q[7];
                                valid_d = 1'b1;
                            end
                        endcase
                    end
                end else if (tcnt_q == TIMEOUT) begin
                    // Keep calling: the engine retries NACKs on its own
                    err_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 20'd1;
                end
            end
            S_GAP: begin
                if (idx_q == last_idx_c) begin
                    state_d = S_IDLE;
                    if (kind_q == KIND_INIT) init_done_d = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_INIT;
            kind_q      <= KIND_INIT;
            idx_q       <= '0;
            set_pend_q  <= 1'b0;
            poll_pend_q <= 1'b0;
            pend_sec_q  <= 8'h00;
            pend_min_q  <= 8'h00;
            pend_hour_q <= 8'h00;
            wrk_sec_q   <= 8'h00;
            wrk_min_q   <= 8'h00;
            wrk_hour_q  <= 8'h00;
            sh_sec_q    <= 8'h00;
            sh_min_q    <= 8'h00;
            pcnt_q      <= 24'd0;
            tcnt_q      <= 20'd0;
            call_q      <= CALL_IDLE;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            hour_q      <= 8'h00;
            vl_q        <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            idx_q       <= idx_d;
            set_pend_q  <= set_pend_d;
            poll_pend_q <= poll_pend_d;
            pend_sec_q  <= pend_sec_d;
            pend_min_q  <= pend_min_d;
            pend_hour_q <= pend_hour_d;
            wrk_sec_q   <= wrk_sec_d;
            wrk_min_q   <= wrk_min_d;
            wrk_hour_q  <= wrk_hour_d;
            sh_sec_q    <= sh_sec_d;
            sh_min_q    <= sh_min_d;
            pcnt_q      <= pcnt_d;
            tcnt_q      <= tcnt_d;
            call_q      <= call_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            vl_q        <= vl_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

    assign oCall     = call_q;
    assign oAddr     = addr_q;
    assign oWrData   = wdata_q;
    assign oSec      = sec_q;
    assign oMin      = min_q;
    assign oHour     = hour_q;
    assign oVL       = vl_q;
    assign oValid    = valid_q;
    assign oBusy     = busy_q;
    assign oInitDone = init_done_q;
    assign oErr      = err_q;

endmodule
